// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter with valid/ready handshakes on both sides.
// A word is loaded into a shifter and sent LSB first, one bit per accepted
// serial transfer. A one-word holding buffer absorbs the next word while the
// current one is still shifting, so a steady stream runs without gaps.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    input  logic             serial_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             busy
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(width - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [width-1:0] shift_q, shift_n;
    logic [CW-1:0]    cnt_q,   cnt_n;
    logic [width-1:0] hold_q,  hold_n;
    logic             full_q,  full_n;

    logic word_xfer;
    logic bit_xfer;
    logic last_bit;

    // Handshake qualifiers. parallel_ready is a pure register decode, so the
    // upstream side never sees a combinational path through this block.
    assign parallel_ready = ~full_q;
    assign word_xfer      = parallel_valid & parallel_ready;
    assign bit_xfer       = (state_q == SHIFT) & serial_ready;
    assign last_bit       = bit_xfer & (cnt_q == LAST_IDX);

    // Outputs come straight from state flops: the current bit always sits in
    // shifter position 0 because the shifter moves right once per transfer.
    assign serial_valid = (state_q == SHIFT);
    assign serial_data  = shift_q[0];
    assign busy         = (state_q == SHIFT) | full_q;

    // Next-state logic for the shifter, bit counter and holding buffer.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_n = state_q;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        hold_n  = hold_q;
        full_n  = full_q;

        case (state_q)
            IDLE: begin
                // The buffer is always empty here, so an accepted word goes
                // straight into the shifter and bit 0 is visible next cycle.
                if (word_xfer) begin
                    shift_n = parallel_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_xfer) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_n   = cnt_q + CW'(1);
                        shift_n = shift_q >> 1;
                    end else begin
                        // Last bit leaves: refill from the buffer first, then
                        // from a word arriving this very cycle, else go idle.
                        cnt_n = '0;
                        if (full_q) begin
                            shift_n = hold_q;
                            full_n  = 1'b0;
                        end else if (word_xfer) begin
                            shift_n = parallel_data;
                        end else begin
                            shift_n = '0;
                            state_n = IDLE;
                        end
                    end
                end

                // A word accepted mid-word parks in the buffer. It cannot
                // collide with a refill from the buffer, because a full
                // buffer holds parallel_ready low.
                if (word_xfer && !last_bit) begin
                    hold_n = parallel_data;
                    full_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that wins over any transfer.
    always_ff @(posedge clk) begin
        // NOTE: the holding buffer is a single word, so it is cleared on reset
        // along with everything else; deeper storage would normally be left
        // unreset and guarded by its full flag instead.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            cnt_q   <= cnt_n;
            hold_q  <= hold_n;
            full_q  <= full_n;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial (width = 8): a table of
// single-cycle vectors, hand-written multi-cycle sequences, and a random
// loopback through a bit-collecting receiver.
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       parallel_valid;
    logic [7:0] parallel_data;
    logic       parallel_ready;
    logic       serial_ready;
    logic       serial_valid;
    logic       serial_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    parallel_to_serial #(.width(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready),
        .serial_ready   (serial_ready),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // One vector: inputs held for one cycle, outputs expected after that edge.
    typedef struct {
        logic       rst;
        logic       pv;
        logic [7:0] pd;
        logic       sr;
        logic       e_pr;
        logic       e_sv;
        logic       e_sd;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic pv, input logic [7:0] pd,
                                input logic sr, input logic e_pr, input logic e_sv,
                                input logic e_sd, input logic e_busy);
        vec_t v;
        v.rst = r;  v.pv = pv;  v.pd = pd;  v.sr = sr;
        v.e_pr = e_pr;  v.e_sv = e_sv;  v.e_sd = e_sd;  v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver: rebuilds words from accepted serial bits, LSB first.
    logic       lb_on = 1'b0;
    logic [7:0] rx_sh = '0;
    int         rx_bits = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        if (lb_on && !rst && serial_valid && serial_ready) begin
            rx_sh <= {serial_data, rx_sh[7:1]};
            if (rx_bits == 7) begin
                rx_q.push_back({serial_data, rx_sh[7:1]});
                rx_bits <= 0;
            end else begin
                rx_bits <= rx_bits + 1;
            end
        end
    end

    // Word a shifts, word b is offered right after and buffered; optionally a
    // third word c is offered the whole time the buffer is full.
    task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic offer_c, input logic [7:0] c);
        logic exp_bit;
        logic exp_pr;
        serial_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                parallel_valid = 1'b1;  parallel_data = a;
            end else if (i == 1) begin
                parallel_valid = 1'b1;  parallel_data = b;
            end else if (offer_c && i <= 8) begin
                parallel_valid = 1'b1;  parallel_data = c;
            end else begin
                parallel_valid = 1'b0;  parallel_data = 8'hEE;
            end
            tick();
            exp_bit = (i < 8) ? a[i] : b[i-8];
            exp_pr  = (i >= 1 && i <= 7) ? 1'b0 : 1'b1;
            check($sformatf("%s_valid[%0d]", tag, i), serial_valid, 1);
            check($sformatf("%s_bit[%0d]", tag, i), serial_data, exp_bit);
            check($sformatf("%s_pready[%0d]", tag, i), parallel_ready, exp_pr);
        end
        parallel_valid = 1'b0;
        tick();
        check({tag, "_end_valid"}, serial_valid, 0);
        check({tag, "_end_busy"}, busy, 0);
    endtask

    // Offer one word from idle and check its eight bits and the gap after.
    task automatic send_word(input string tag, input logic [7:0] w);
        parallel_valid = 1'b1;
        parallel_data  = w;
        serial_ready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            parallel_valid = 1'b0;
            parallel_data  = ~w;
            check($sformatf("%s_valid[%0d]", tag, i), serial_valid, 1);
            check($sformatf("%s_bit[%0d]", tag, i), serial_data, w[i]);
        end
        tick();
        check({tag, "_end_valid"}, serial_valid, 0);
        check({tag, "_end_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] sent[$];
        logic [7:0] w;
        int         guard;

        rst = 1'b1;  parallel_valid = 1'b0;  parallel_data = '0;  serial_ready = 1'b0;

        // Reset rows, single word 8'hA5, then 8'hF0 with a 3-cycle stall at bit 3.
        tbl.push_back(mk(1, 1, 8'h77, 1,  1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h77, 1,  1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'hFF, 1,  1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hF0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1,  1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst            = tbl[i].rst;
            parallel_valid = tbl[i].pv;
            parallel_data  = tbl[i].pd;
            serial_ready   = tbl[i].sr;
            tick();
            check($sformatf("vec%0d_pready", i), parallel_ready, tbl[i].e_pr);
            check($sformatf("vec%0d_valid", i), serial_valid, tbl[i].e_sv);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_sv || tbl[i].rst)
                check($sformatf("vec%0d_bit", i), serial_data, tbl[i].e_sd);
        end
        rst = 1'b0;

        // Back-to-back words, then a full buffer refusing a third word.
        run_pair("b2b", 8'h01, 8'h80, 1'b0, 8'h00);
        run_pair("full", 8'hC3, 8'h3C, 1'b1, 8'h55);

        // Reset after four bits of 8'hFF with 8'hAA buffered; a word offered
        // during reset must not be taken.
        parallel_valid = 1'b1;  parallel_data = 8'hFF;  serial_ready = 1'b1;
        tick();
        parallel_data = 8'hAA;
        tick();
        parallel_valid = 1'b0;
        repeat (3) tick();
        check("rstmid_pre_pready", parallel_ready, 0);
        check("rstmid_pre_valid", serial_valid, 1);
        rst = 1'b1;  parallel_valid = 1'b1;  parallel_data = 8'h33;
        tick();
        check("rstmid_valid", serial_valid, 0);
        check("rstmid_pready", parallel_ready, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_bit", serial_data, 0);
        rst = 1'b0;  parallel_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstmid_quiet[%0d]", i), serial_valid, 0);
        end
        send_word("after_rst", 8'h0F);

        // Loopback: random words, random serial_ready, random idle gaps.
        lb_on = 1'b1;
        for (int n = 0; n < 24; n++) begin
            w = 8'($urandom);
            sent.push_back(w);
            parallel_valid = 1'b1;
            parallel_data  = w;
            guard = 0;
            while (!parallel_ready && guard < 100) begin
                serial_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            if (guard >= 100) check($sformatf("lb_accept_timeout[%0d]", n), 0, 1);
            serial_ready = 1'($urandom_range(0, 1));
            tick();
            parallel_valid = 1'b0;
            parallel_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                serial_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        serial_ready = 1'b1;
        guard = 0;
        while (rx_q.size() < sent.size() && guard < 400) begin
            tick();
            guard++;
        end
        tick();
        check("lb_count", rx_q.size(), sent.size());
        for (int n = 0; n < sent.size() && n < rx_q.size(); n++)
            check($sformatf("lb_word[%0d]", n), rx_q[n], sent[n]);
        check("lb_end_valid", serial_valid, 0);
        check("lb_end_busy", busy, 0);
        lb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
